// File: rtl/fchan_pkg.sv
// fchan_pkg: types and default parameter values shared by the fchan capture
// path. The optional trigger timestamp is enabled with FCHAN_CAPTURE_TSTAMP_EN.
package fchan_pkg;

  // Capture controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Default sample width; matches the subset stage output width
  localparam int DW_DEF = 20;
  // Default address width; capture depth is 2**AW_DEF
  localparam int AW_DEF = 10;
  // Default timestamp width
  localparam int TW_DEF = 32;

endpackage : fchan_pkg

// File: rtl/fchan_capture_dpram.sv
// dpram: simple dual-port RAM, one write port and one registered read port.
// A read of the address being written in the same cycle returns the old word.
// Contents are never reset; only the read register clears on rst.
module dpram #(
  parameter int dw = 20,
  parameter int aw = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [aw-1:0]        waddr,
  input  logic signed [dw-1:0] wdata,
  input  logic [aw-1:0]        raddr,
  output logic signed [dw-1:0] rdata
);

  logic signed [dw-1:0] mem [2**aw];
  logic signed [dw-1:0] rdata_d;
  logic signed [dw-1:0] rdata_q;

  // Storage write port; contents are left untouched by reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read of the stored word, before any same-edge write lands
  always_comb begin
    rdata_d = mem[raddr];
  end

  // Registered read port with one cycle of latency
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule : dpram

// File: rtl/fchan_capture.sv
// fchan_capture: waveform capture buffer behind the channel-subset stage.
// Once armed it waits for a block trigger, then stores each gated sample
// until the memory is full. Optional trigger timestamp: FCHAN_CAPTURE_TSTAMP_EN.
module fchan_capture
  import fchan_pkg::*;
#(
  parameter int dw = DW_DEF,
  parameter int aw = AW_DEF,
  parameter int tw = TW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [dw-1:0] d_data,
  input  logic                 d_gate,
  input  logic                 d_trig,
  input  logic                 arm,
  input  logic [aw-1:0]        raddr,
  output logic signed [dw-1:0] rdata,
  output logic                 busy,
  output logic                 done,
`ifdef FCHAN_CAPTURE_TSTAMP_EN
  output logic [tw-1:0]        trig_ts,
`endif
  output logic [aw:0]          wcount
);

  // Count value held before the write that fills the last location
  localparam logic [aw:0] LAST_COUNT = (aw+1)'((1 << aw) - 1);

  // Reject degenerate parameter values at elaboration
  if (dw < 1 || aw < 1 || tw < 1) begin : g_param_check
    $error("fchan_capture: dw, aw and tw must all be at least 1");
  end

  state_e        state_d, state_q;
  logic          busy_d, busy_q;
  logic          done_d, done_q;
  logic [aw:0]   wcount_d, wcount_q;
  logic [aw-1:0] waddr_d, waddr_q;
  logic          we;

  // Next-state, counter and write-enable decode for the capture controller
  always_comb begin
    state_d  = state_q;
    wcount_d = wcount_q;
    waddr_d  = waddr_q;
    we       = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // arm wins over a coincident trigger; the trigger is simply dropped
        if (arm) begin
          state_d  = ST_ARMED;
          wcount_d = '0;
          waddr_d  = '0;
        end
      end
      ST_ARMED: begin
        // Gated samples before the trigger are not part of the record
        if (d_trig) begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (d_gate) begin
          we       = 1'b1;
          waddr_d  = waddr_q + 1'b1;
          wcount_d = wcount_q + 1'b1;
          if (wcount_q == LAST_COUNT) begin
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_ARMED) || (state_d == ST_FILL);
    done_d = (state_d == ST_DONE);
  end

  // Controller state and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wcount_q <= '0;
      waddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wcount_q <= wcount_d;
      waddr_q  <= waddr_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign wcount = wcount_q;

`ifdef FCHAN_CAPTURE_TSTAMP_EN
  logic [tw-1:0] ts_cnt_d, ts_cnt_q;
  logic [tw-1:0] trig_ts_d, trig_ts_q;

  // Free-running counter and latch of its value on the ARMED->FILL trigger
  always_comb begin
    ts_cnt_d  = ts_cnt_q + 1'b1;
    trig_ts_d = trig_ts_q;
    if (state_q == ST_ARMED && d_trig) begin
      trig_ts_d = ts_cnt_q;
    end
  end

  // Timestamp registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt_q  <= '0;
      trig_ts_q <= '0;
    end else begin
      ts_cnt_q  <= ts_cnt_d;
      trig_ts_q <= trig_ts_d;
    end
  end

  assign trig_ts = trig_ts_q;
`endif

  dpram #(
    .dw(dw),
    .aw(aw)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .waddr(waddr_q),
    .wdata(d_data),
    .raddr(raddr),
    .rdata(rdata)
  );

endmodule : fchan_capture

// File: tb/tb_fchan_capture.sv
// tb_fchan_capture: directed bench for fchan_capture at aw=4, dw=20.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// Timestamp checks are built when FCHAN_CAPTURE_TSTAMP_EN is defined.
module tb_fchan_capture;

  localparam int DW = 20;
  localparam int AW = 4;
  localparam int TW = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] d_data;
  logic          d_gate;
  logic          d_trig;
  logic          arm;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          done;
  logic [AW:0]   wcount;
`ifdef FCHAN_CAPTURE_TSTAMP_EN
  logic [TW-1:0] trig_ts;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  int            wr_ptr;

  fchan_capture #(
    .dw(DW),
    .aw(AW),
    .tw(TW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .d_data (d_data),
    .d_gate (d_gate),
    .d_trig (d_trig),
    .arm    (arm),
    .raddr  (raddr),
    .rdata  (rdata),
    .busy   (busy),
    .done   (done),
`ifdef FCHAN_CAPTURE_TSTAMP_EN
    .trig_ts(trig_ts),
`endif
    .wcount (wcount)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic a, input logic t, input logic g, input logic [DW-1:0] dat);
    arm    = a;
    d_trig = t;
    d_gate = g;
    d_data = dat;
    tick();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0);
  endtask

  // Gated sample while the bench expects FILL; updates the memory model
  task automatic fill_sample(input logic t, input logic [DW-1:0] dat);
    model_mem[wr_ptr] = dat;
    wr_ptr = (wr_ptr + 1) % DEPTH;
    drive(1'b0, t, 1'b1, dat);
  endtask

  // Scoreboard read: expected word queued at issue, popped when rdata is valid
  task automatic read_chk(input int a, input string tag);
    exp_q.push_back(model_mem[a]);
    raddr = AW'(a);
    idle();
    chk(tag, 32'(rdata), 32'(exp_q.pop_front()));
  endtask

  task automatic status_chk(input string tag, input logic b, input logic d, input int wc);
    chk({tag, "_busy"}, 32'(busy), 32'(b));
    chk({tag, "_done"}, 32'(done), 32'(d));
    chk({tag, "_wcount"}, 32'(wcount), 32'(wc));
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; d_trig = 1'b0; d_gate = 1'b0; d_data = '0; raddr = '0;
    wr_ptr = 0;
    foreach (model_mem[i]) model_mem[i] = '0;

    // Reset state
    tick(); tick();
    status_chk("reset", 1'b0, 1'b0, 0);
    chk("reset_rdata", 32'(rdata), 32'd0);
    rst = 1'b0;

    // Basic fill: arm, trigger, 16 samples on alternate cycles
    drive(1'b1, 1'b0, 1'b0, '0);
    status_chk("arm", 1'b1, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b0, '0);
    status_chk("trig", 1'b1, 1'b0, 0);
    wr_ptr = 0;
    for (int i = 0; i < DEPTH; i++) begin
      fill_sample(1'b0, DW'(i));
      if (i == 7) status_chk("fill_mid", 1'b1, 1'b0, 8);
      if (i < DEPTH - 1) idle();
    end
    status_chk("fill_done", 1'b0, 1'b1, DEPTH);
    for (int a = 0; a < DEPTH; a++) read_chk(a, "basic_rd");

    // Overflow: gates after done are ignored
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, DW'(100 + i));
    status_chk("overflow", 1'b0, 1'b1, DEPTH);
    for (int a = 0; a < 4; a++) read_chk(a, "overflow_rd");

    // Pre-trigger gating: gates in ARMED are dropped
    drive(1'b1, 1'b0, 1'b0, '0);
    status_chk("rearm", 1'b1, 1'b0, 0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, DW'(200 + i));
    status_chk("pretrig", 1'b1, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b0, '0);
    wr_ptr = 0;
    fill_sample(1'b0, DW'(300));
    status_chk("posttrig", 1'b1, 1'b0, 1);
    // arm during FILL is ignored and the gated sample is still taken
    model_mem[wr_ptr] = DW'(301);
    wr_ptr++;
    drive(1'b1, 1'b0, 1'b1, DW'(301));
    status_chk("arm_in_fill", 1'b1, 1'b0, 2);
    // Sustained one-per-cycle capture; trigger with gate still writes
    for (int i = 2; i < DEPTH; i++) fill_sample(i == 5, DW'(300 + i));
    status_chk("sustained_done", 1'b0, 1'b1, DEPTH);
    for (int a = 0; a < DEPTH; a += 5) read_chk(a, "pretrig_rd");

    // arm and trigger together from DONE: only ARMED
    drive(1'b1, 1'b1, 1'b0, '0);
    status_chk("arm_trig", 1'b1, 1'b0, 0);
    drive(1'b0, 1'b0, 1'b1, DW'(400));
    status_chk("arm_trig_gate", 1'b1, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b0, '0);
    wr_ptr = 0;
    for (int i = 1; i <= 7; i++) fill_sample(1'b0, DW'(400 + i));
    status_chk("seven", 1'b1, 1'b0, 7);

    // Reset mid-capture
    rst = 1'b1;
    idle();
    rst = 1'b0;
    status_chk("mid_rst", 1'b0, 1'b0, 0);
    for (int a = 0; a < 7; a++) read_chk(a, "mid_rst_rd");

    // Re-arm overwrites from address 0; same-cycle read sees the old word
    drive(1'b1, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b0, '0);
    wr_ptr = 0;
    exp_q.push_back(model_mem[0]);
    raddr = '0;
    fill_sample(1'b0, DW'(500));
    chk("rbw", 32'(rdata), 32'(exp_q.pop_front()));
    status_chk("rearm_wr", 1'b1, 1'b0, 1);
    read_chk(0, "rearm_rd0");
    read_chk(1, "rearm_rd1");

`ifdef FCHAN_CAPTURE_TSTAMP_EN
    // Timestamp: release at cycle 0, arm at 3, trigger at 10
    begin
      int trig_cyc;
      rst = 1'b1;
      idle();
      chk("ts_reset", trig_ts, 32'd0);
      rst = 1'b0;
      cyc = 0;
      for (int i = 0; i < 3; i++) idle();
      drive(1'b1, 1'b0, 1'b0, '0);
      for (int i = 4; i < 10; i++) idle();
      drive(1'b0, 1'b1, 1'b0, '0);
      chk("ts_first", trig_ts, 32'd10);
      idle();
      chk("ts_hold", trig_ts, 32'd10);
      for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b0, 1'b1, DW'(i));
      status_chk("ts_fill", 1'b0, 1'b1, DEPTH);
      drive(1'b1, 1'b0, 1'b0, '0);
      idle(); idle();
      trig_cyc = cyc;
      drive(1'b0, 1'b1, 1'b0, '0);
      chk("ts_second", trig_ts, 32'(trig_cyc));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fchan_capture

// File: doc/fchan_capture.md
# fchan_capture

Waveform capture buffer that sits directly downstream of the channel-subset stage. It consumes that stage's o_data/o_gate/o_trig stream and, once armed, waits for a block trigger. It then writes every gated sample into a dual-port memory until the memory is full, and exposes the captured record to the host through a registered read port.

## Interface
Parameters:
- dw, 20: sample width; must match the subset stage's o_dw.
- aw, 10: memory address width; capture depth is 2^aw samples.
- tw, 32: timestamp width; used only with FCHAN_CAPTURE_TSTAMP_EN.

Ports:
- clk, input, 1: sole clock.
- rst, input, 1: synchronous, active-high reset.
- d_data, input, dw (signed): sample from the subset stage (o_data).
- d_gate, input, 1: sample valid (o_gate).
- d_trig, input, 1: block-start marker (o_trig).
- arm, input, 1: host single-cycle pulse that starts a new capture.
- raddr, input, aw: host read address.
- rdata, output, dw (signed): memory word at raddr.
- busy, output, 1: capture in progress (ARMED or FILL).
- done, output, 1: capture complete and memory full.
- wcount, output, aw+1: number of samples written in the current capture.
- trig_ts, output, tw: timestamp latched at capture start. Present only with FCHAN_CAPTURE_TSTAMP_EN.

## Operation
- State machine with four states: IDLE, ARMED, FILL, DONE.
- Reset:
  - state goes to IDLE.
  - busy=0, done=0, wcount=0, internal waddr=0, rdata=0, trig_ts=0.
  - Memory contents are not cleared.
- IDLE or DONE:
  - arm=1 moves to ARMED and clears done, wcount and waddr.
  - d_trig and d_gate are ignored. If arm and d_trig arrive in the same cycle, arm wins and the trigger is not seen.
- ARMED:
  - d_gate is ignored.
  - d_trig=1 moves to FILL. The first captured sample is the first d_gate on a later cycle.
- FILL:
  - Each cycle with d_gate=1 writes d_data to mem[waddr], then increments waddr and wcount.
  - d_trig has no effect in FILL. d_gate and d_trig together in one cycle still write the sample.
  - The write that brings wcount to 2^aw moves to DONE. waddr wraps to 0; that value is unused.
- DONE: further d_gate pulses are ignored; wcount holds at 2^aw.
- arm during ARMED or FILL is ignored; a capture cannot be aborted except by rst.
- rst asserted in any state, including mid-FILL, returns to IDLE. Partially written memory remains readable.
- Reads:
  - Permitted in every state with no interlock.
  - Reading an address being written in the same cycle returns the old word (read-before-write).
- Arithmetic: wcount is an unsigned aw+1-bit count and never exceeds 2^aw. waddr is aw bits and wraps modulo 2^aw.

## Timing
- State, busy, done and wcount are registered; each reflects an input event on the cycle after it.
- arm at cycle N gives busy=1 at N+1.
- d_trig at N (in ARMED) gives state FILL at N+1. A d_gate at N+1 is captured.
- A gated sample at cycle N is written at the N clock edge; wcount shows the new value at N+1.
- Final write at cycle N gives done=1 and busy=0 at N+1.
- rdata has one-cycle latency: raddr at N appears on rdata at N+1.
- Sustained capture rate is one sample per cycle (d_gate held high).

## Configuration
- Macro: FCHAN_CAPTURE_TSTAMP_EN.
- Defined:
  - A free-running tw-bit counter resets to 0 and wraps modulo 2^tw.
  - Its value on the cycle d_trig moves ARMED to FILL is latched into trig_ts.
  - trig_ts holds until the next such transition or rst.
- Undefined: the counter, the latch and the trig_ts port are all absent. All other behaviour is identical.

## Structure
- Shared package fchan_pkg:
  - state enum typedef (IDLE, ARMED, FILL, DONE);
  - default parameter constants for dw, aw and tw.
- One sub-module: dpram.
  - Simple dual-port RAM with one write port and one registered read port, read-before-write, no reset on contents.
  - Instantiated once, with dw and aw.
- Control FSM, counters and timestamp logic live in fchan_capture.

## Test plan
Parameters aw=4 (depth 16), dw=20 for all scenarios.
- Basic fill:
  - Stimulus: arm; d_trig; then 16 gated samples 0..15, with d_gate high on alternate cycles.
  - Response: done=1 one cycle after the 16th write, wcount=16, busy=0; reading raddr 0..15 returns 0..15 with 1-cycle latency.
- Pre-trigger gating:
  - Stimulus: arm; 5 d_gate pulses before the first d_trig.
  - Response: wcount stays 0 and state stays ARMED; the first post-trigger sample lands at address 0.
- Overflow:
  - Stimulus: after done, 4 more d_gate pulses.
  - Response: wcount stays 16; mem[0..3] is unchanged.
- Collisions:
  - arm and d_trig in the same cycle from IDLE: enters ARMED only; a second d_trig is needed to start filling.
  - arm during FILL: ignored; wcount continues counting.
- Reset mid-capture:
  - Stimulus: rst after 7 writes.
  - Response: next cycle busy=0, done=0, wcount=0; mem[0..6] still read back; a re-arm overwrites from address 0.
- Timestamp (with FCHAN_CAPTURE_TSTAMP_EN):
  - Stimulus: rst released at cycle 0, arm at cycle 3, d_trig at cycle 10.
  - Response: trig_ts=10 from cycle 11; a second capture updates it.
  - Also compile without the macro and confirm the port is absent.
